logicbox_arbiter: RTL and testbench
===================================

Name: logicbox_arbiter

Overview:
Round-robin arbiter that shares one LOGICBOX-style whitebox pass-through cell between N_REQ requesters. It grants one requester at a time and steers that requester's data bit into the shared box input (BOX_I). It captures the box output (BOX_O) back into that requester's output bit. It sits between requester logic and the shared cell, and gives fair, bounded-latency access with preemption after MAX_HOLD cycles.

Parameters:
N_REQ, 4, number of requesters (2..16)
MAX_HOLD, 8, max consecutive grant cycles before forced re-arbitration when others wait (>=1)

Ports:
CLK  input  1  clock, rising edge
RST_N  input  1  asynchronous active-low reset
REQ  input  N_REQ  per-requester request, level-sensitive
I  input  N_REQ  per-requester data bit to send through shared box
GNT  output  N_REQ  one-hot grant, registered
BOX_I  output  1  drive to shared box input
BOX_O  input  1  return from shared box output
O  output  N_REQ  per-requester captured box result, registered
VALID  output  N_REQ  one-hot; VALID[k]=1 for the cycle O[k] was just updated

Behaviour:
- Reset, asynchronous on RST_N=0: GNT=0, O=0, VALID=0, ptr=0, hold_cnt=0, state=IDLE. BOX_I=0 while GNT=0.
- Clock and reset: one clock (CLK); reset is asynchronous and active-low (RST_N). Deassertion is sampled synchronously by the design's reset synchroniser upstream; this block only uses RST_N as an async clear.
- State IDLE:
  - If REQ!=0, pick the first set REQ bit scanning ptr, ptr+1, ..., wrapping modulo N_REQ.
  - Next cycle: GNT=onehot(g), state=BUSY, hold_cnt=0, ptr=(g+1) mod N_REQ.
  - Grant latency from REQ rise in IDLE is 1 cycle.
- State BUSY, grant index g:
  - BOX_I = I[g] combinationally; BOX_I=0 when GNT=0.
  - Each BUSY cycle: O[g] <= BOX_O, VALID <= onehot(g). Other O bits hold their value. VALID is 0 in cycles following IDLE.
  - hold_cnt increments each BUSY cycle and saturates at MAX_HOLD-1.
- Release (REQ[g]=0 sampled in BUSY):
  - The capture in that cycle still occurs.
  - If any other REQ is set: direct hand-off next cycle to the round-robin winner from ptr, with no idle bubble; ptr and hold_cnt update as for a new grant.
  - Otherwise: GNT=0, state=IDLE.
- Preemption: hold_cnt==MAX_HOLD-1 with REQ[g]=1 and any other REQ bit set → hand-off next cycle as on release. If no other requester is waiting, the grant persists and hold_cnt stays saturated.
- The current holder is excluded from the winner scan only on preemption. On release it is already deasserted.
- Simultaneous requests always resolve by ptr order. At most one GNT bit is ever set (checked by assertion).
- REQ bits for non-granted requesters may toggle freely; they are only sampled at arbitration points.
- Reset mid-grant: all outputs clear immediately, with no capture on that edge.
- BOX path is treated as combinational delay. BOX_O is sampled on the same edge BOX_I was driven.

Test Plan:
- Reset then single requester: REQ=0b0010, I[1]=1, box loopback → GNT=0b0010 on cycle 1. From cycle 2, O[1]=1 and VALID=0b0010 each cycle. Drop REQ[1] → GNT=0 next cycle, VALID=0 the cycle after.
- Simultaneous all-request: REQ=0b1111 held, MAX_HOLD=8 → grants rotate 0,1,2,3,0 with each holding exactly 8 cycles and no gap cycles.
- Hand-off on release: GNT=0b0001 with REQ=0b0101; drop REQ[0] at cycle t → GNT=0b0100 at t+1, ptr=3.
- Preemption without competitors: REQ=0b1000 held 20 cycles → GNT stays 0b1000 all 20 cycles and O[3] tracks I[3] each cycle.
- Fairness wrap: ptr=3, REQ=0b1001 arriving together in IDLE → GNT=0b1000 first, then 0b0001.
- Async reset mid-BUSY: assert RST_N=0 between edges → GNT, O, VALID, BOX_I go to 0 immediately. After release, REQ=0b0100 → GNT=0b0100 (ptr restarted at 0).

Source files
------------

// File: rtl/logicbox_arbiter_if.sv
// rtl/logicbox_arbiter_if.sv - requester/shared-box bus for the logicbox round-robin arbiter
interface logicbox_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0] REQ;
    logic [N_REQ-1:0] I;
    logic [N_REQ-1:0] GNT;
    logic             BOX_I;
    logic             BOX_O;
    logic [N_REQ-1:0] O;
    logic [N_REQ-1:0] VALID;

    // Requester logic and the shared box drive REQ/I/BOX_O and observe the rest.
    modport master (
        output REQ,
        output I,
        output BOX_O,
        input  GNT,
        input  BOX_I,
        input  O,
        input  VALID
    );

    // The arbiter itself.
    modport slave (
        input  REQ,
        input  I,
        input  BOX_O,
        output GNT,
        output BOX_I,
        output O,
        output VALID
    );
endinterface

// File: rtl/logicbox_arbiter.sv
// rtl/logicbox_arbiter.sv - round-robin arbiter sharing one pass-through box among requesters
module logicbox_arbiter #(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    logicbox_arbiter_if.slave    bus
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_SAT = HW'(MAX_HOLD - 1);
    localparam logic [PW-1:0] LAST_IDX = PW'(N_REQ - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [PW-1:0]     gidx_q, gidx_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [N_REQ-1:0]  o_q, o_d;
    logic [N_REQ-1:0]  valid_q, valid_d;

    logic [N_REQ-1:0]  holder_mask;
    logic [N_REQ-1:0]  others;
    logic [N_REQ-1:0]  req_pick_mask;
    logic [PW-1:0]     winner;

    // First set bit of m scanning p, p+1, ... with wrap-around.
    function automatic logic [PW-1:0] rr_pick(input logic [N_REQ-1:0] m,
                                              input logic [PW-1:0]    p);
        logic [PW-1:0] r;
        logic [PW:0]   s;
        logic [PW-1:0] cand;
        logic          found;
        r     = '0;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            s = {1'b0, p} + (PW+1)'(k);
            if (s >= (PW+1)'(N_REQ)) begin
                s = s - (PW+1)'(N_REQ);
            end
            cand = s[PW-1:0];
            if (!found && m[cand]) begin
                r     = cand;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [PW-1:0] idx);
        return {{(N_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + 1'b1;
    endfunction

    assign holder_mask = onehot(gidx_q);
    assign others      = bus.REQ & ~holder_mask;

    // In IDLE everyone competes; in BUSY only the other requesters can win a hand-off.
    assign req_pick_mask = (state_q == IDLE) ? bus.REQ : others;
    assign winner        = rr_pick(req_pick_mask, ptr_q);

    // Next-state logic: arbitration, capture of the box result, hold counting.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        o_d     = o_q;
        valid_d = '0;

        case (state_q)
            IDLE: begin
                if (|bus.REQ) begin
                    state_d = BUSY;
                    gnt_d   = onehot(winner);
                    gidx_d  = winner;
                    ptr_d   = ptr_after(winner);
                    hold_d  = '0;
                end
            end

            BUSY: begin
                // The box result is captured on every busy edge, including release and hand-off.
                o_d[gidx_q] = bus.BOX_O;
                valid_d     = holder_mask;

                if (!bus.REQ[gidx_q] || ((hold_q == HOLD_SAT) && (|others))) begin
                    if (|others) begin
                        gnt_d  = onehot(winner);
                        gidx_d = winner;
                        ptr_d  = ptr_after(winner);
                        hold_d = '0;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end else if (hold_q != HOLD_SAT) begin
                    hold_d = hold_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State and output registers; reset clears everything asynchronously.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            o_q     <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            o_q     <= o_d;
            valid_q <= valid_d;
        end
    end

    assign bus.GNT   = gnt_q;
    assign bus.O     = o_q;
    assign bus.VALID = valid_q;
    // Masking with the grant keeps the box input low whenever nobody holds it.
    assign bus.BOX_I = |(gnt_q & bus.I);

    a_gnt_onehot0: assert property (@(posedge CLK) disable iff (!RST_N) $onehot0(gnt_q));
endmodule

// File: tb/tb_logicbox_arbiter.sv
// tb/tb_logicbox_arbiter.sv - directed table-driven bench for logicbox_arbiter
module tb_logicbox_arbiter;
    logic clk;
    logic rst_n;
    logic box_inv;
    int   checks;
    int   errors;

    logicbox_arbiter_if #(.N_REQ(4)) bus ();

    assign bus.BOX_O = bus.BOX_I ^ box_inv;

    logicbox_arbiter #(.N_REQ(4), .MAX_HOLD(8)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] i;
        logic       inv;
        logic [3:0] gnt;
        logic [3:0] o;
        logic [3:0] valid;
    } vec_t;

    vec_t tv [17];

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [3:0] cur_i;
    logic [3:0] exp_gnt;

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        box_inv = 1'b0;
        bus.REQ = '0;
        bus.I   = '0;

        //          req      i        inv   gnt      o        valid
        tv[0]  = '{4'b0010, 4'b0010, 1'b0, 4'b0010, 4'b0000, 4'b0000};
        tv[1]  = '{4'b0010, 4'b0010, 1'b0, 4'b0010, 4'b0010, 4'b0010};
        tv[2]  = '{4'b0010, 4'b0000, 1'b0, 4'b0010, 4'b0000, 4'b0010};
        tv[3]  = '{4'b0010, 4'b0010, 1'b0, 4'b0010, 4'b0010, 4'b0010};
        tv[4]  = '{4'b0000, 4'b0010, 1'b0, 4'b0000, 4'b0010, 4'b0010};
        tv[5]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0010, 4'b0000};
        tv[6]  = '{4'b0100, 4'b0000, 1'b0, 4'b0100, 4'b0010, 4'b0000};
        tv[7]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0010, 4'b0100};
        tv[8]  = '{4'b1001, 4'b1001, 1'b0, 4'b1000, 4'b0010, 4'b0000};
        tv[9]  = '{4'b1001, 4'b1001, 1'b0, 4'b1000, 4'b1010, 4'b1000};
        tv[10] = '{4'b0001, 4'b0001, 1'b0, 4'b0001, 4'b0010, 4'b1000};
        tv[11] = '{4'b0101, 4'b0101, 1'b0, 4'b0001, 4'b0011, 4'b0001};
        tv[12] = '{4'b0100, 4'b0100, 1'b0, 4'b0100, 4'b0010, 4'b0001};
        tv[13] = '{4'b0100, 4'b0100, 1'b1, 4'b0100, 4'b0010, 4'b0100};
        tv[14] = '{4'b0100, 4'b0000, 1'b1, 4'b0100, 4'b0110, 4'b0100};
        tv[15] = '{4'b0110, 4'b0000, 1'b0, 4'b0100, 4'b0010, 4'b0100};
        tv[16] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0010, 4'b0100};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_gnt", bus.GNT, 4'b0000);
        chk("reset_o", bus.O, 4'b0000);
        chk("reset_valid", bus.VALID, 4'b0000);
        chk("reset_box_i", {3'b000, bus.BOX_I}, 4'b0000);
        rst_n = 1'b1;

        // Table: single requester, release, wrap from ptr=3, hand-off, inverted box
        for (int n = 0; n < 17; n++) begin
            bus.REQ = tv[n].req;
            bus.I   = tv[n].i;
            box_inv = tv[n].inv;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_gnt", n), bus.GNT, tv[n].gnt);
            chk($sformatf("vec%0d_o", n), bus.O, tv[n].o);
            chk($sformatf("vec%0d_valid", n), bus.VALID, tv[n].valid);
            chk($sformatf("vec%0d_box_i", n), {3'b000, bus.BOX_I},
                {3'b000, |(tv[n].gnt & tv[n].i)});
        end
        box_inv = 1'b0;

        // All requesting: each holder keeps the grant exactly 8 cycles, no gaps
        bus.REQ = '0;
        pulse_reset();
        bus.REQ = 4'b1111;
        bus.I   = 4'b1111;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            exp_gnt = 4'b0001 << (((c - 1) / 8) % 4);
            chk($sformatf("rotate_c%0d", c), bus.GNT, exp_gnt);
        end

        // Lone requester past MAX_HOLD: grant persists, O[3] follows I[3]
        bus.REQ = '0;
        pulse_reset();
        bus.REQ = 4'b1000;
        bus.I   = 4'($urandom_range(0, 15));
        for (int c = 1; c <= 20; c++) begin
            cur_i = bus.I;
            @(posedge clk);
            #1;
            chk($sformatf("solo_gnt_c%0d", c), bus.GNT, 4'b1000);
            if (c >= 2) begin
                chk($sformatf("solo_o3_c%0d", c), {3'b000, bus.O[3]}, {3'b000, cur_i[3]});
            end
            bus.I = 4'($urandom_range(0, 15));
        end

        // Async reset mid-grant, then ptr must restart at 0
        bus.REQ = '0;
        pulse_reset();
        bus.REQ = 4'b0010;
        bus.I   = 4'b0010;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_areset_o", bus.O, 4'b0010);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_gnt", bus.GNT, 4'b0000);
        chk("areset_o", bus.O, 4'b0000);
        chk("areset_valid", bus.VALID, 4'b0000);
        chk("areset_box_i", {3'b000, bus.BOX_I}, 4'b0000);
        #2;
        rst_n   = 1'b1;
        bus.REQ = 4'b0101;
        bus.I   = 4'b0000;
        @(posedge clk);
        #1;
        chk("post_areset_gnt", bus.GNT, 4'b0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
